fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction buffer between the fetch stage (pif) and the IF/ID register.
//  Decouples fetch from decode back-pressure: pif pushes {pc, inst} pairs,
//  and ifid pops them when decode can accept.
//  On a jump/branch redirect, the whole queue is discarded in one cycle.
// PARAMETERS
//  DEPTH   8   entries; power of two, >= 2
//  ADDR_W  32  PC width
//  INST_W  32  instruction width
// PORTS
//  clk        in   1              system clock, all state on posedge
//  rst        in   1              synchronous, active-high reset
//  flush      in   1              redirect (jump_ce); discard all entries
//  enq_valid  in   1              pif offers an entry
//  enq_ready  out  1              queue can accept this cycle
//  enq_pc     in   ADDR_W         PC of offered instruction
//  enq_inst   in   INST_W         offered instruction word
//  deq_valid  out  1              head entry is valid
//  deq_ready  in   1              ifid consumes the head (deassert = stall)
//  deq_pc     out  ADDR_W         head PC
//  deq_inst   out  INST_W         head instruction
//  count      out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: circular array of DEPTH entries.
//  - head/tail pointers are PTR_W=$clog2(DEPTH)+1 bits; the MSB is the wrap bit.
//    empty = (head==tail); full = index bits equal and wrap bits differ.
//  - Reset (rst=1 at posedge): head=tail=0.
//  - While rst is high: enq_ready=0, deq_valid=0, count=0, deq_pc=0, deq_inst=0.
//  - Array contents are not reset.
//  - enq_ready = !full && !rst.
//    It depends on state only, never on deq_ready (no combinational path).
//    A full queue therefore refuses enqueue even when a dequeue happens that cycle.
//  - deq_valid = !empty && !rst.
//  - deq_pc/deq_inst are read combinationally from the head entry.
//    Both are forced to 0 when empty.
//  - Enqueue fires on enq_valid && enq_ready:
//    write array[tail], then tail+1 at the posedge.
//  - Dequeue fires on deq_valid && deq_ready: head+1 at the posedge.
//  - Latency: an entry enqueued at edge N is visible on deq_* after edge N;
//    it can be dequeued in cycle N+1 at the earliest. There is no fall-through.
//  - Simultaneous enqueue and dequeue (not full, not empty): count unchanged,
//    and both pointers advance.
//  - Wrap-around: index bits roll over from DEPTH-1 to 0 and the wrap bit toggles.
//    Ordering is strictly FIFO across the wrap.
//  - flush=1 at a posedge: head=tail=0.
//    Any enqueue or dequeue firing that same cycle is ignored.
//    deq_valid=0 and count=0 on the following cycle.
//  - Priority: rst > flush > enq/deq.
//  - rst or flush in mid-operation drops all in-flight entries.
//    No partial state survives.
//  - deq_valid && !deq_ready holds deq_pc/deq_inst stable until the entry is
//    consumed or flushed.
//  - count = tail - head (PTR_W-bit subtraction), registered-state derived.
// STRUCTURE
//  - common_def.h gains a packed struct fq_entry_t {pc[ADDR_W], inst[INST_W]}
//    and the constant FQ_DEPTH.
//  - The pif/ifid interfaces consume fq_entry_t.
//  - One sub-module, fq_ptr: a PTR_W wrap-bit counter with sync clear and
//    increment enable, instantiated for head and tail.
//  - Full/empty/count logic stays in fetch_queue.
// TESTING
//  1 Reset: hold rst 2 cycles, push enq_valid=1 during rst
//    -> enq_ready=0, deq_valid=0, count=0; no entry stored after release.
//  2 Fill: push 8 entries pc=0x0,0x4..0x1C with deq_ready=0
//    -> count=8, enq_ready=0; 9th offer not accepted; then drain in order 0x0..0x1C.
//  3 Stream: enq and deq every cycle for 20 cycles (pointers wrap twice)
//    -> count stays 1; outputs match inputs in order, delayed 1 cycle.
//  4 Full+deq: queue full, enq_valid=1, deq_ready=1 same cycle
//    -> count 8->7, offered entry dropped by source (enq_ready was 0).
//  5 Flush: count=5, assert flush with enq_valid=1 and deq_ready=1
//    -> next cycle count=0, deq_valid=0, deq_pc=0; next enqueue appears at head.
//  6 Stall hold: deq_ready=0 for 4 cycles with head pc=0x40
//    -> deq_pc=0x40 and deq_inst stable for all 4 cycles; then pops once.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch-queue entry type and default sizing
package fetch_queue_pkg;
    localparam int FQ_DEPTH  = 8;
    localparam int FQ_ADDR_W = 32;
    localparam int FQ_INST_W = 32;
    typedef struct packed {
        logic [FQ_ADDR_W-1:0] pc;
        logic [FQ_INST_W-1:0] inst;
    } fq_entry_t;
endpackage

// File: rtl/fq_ptr.sv
// fq_ptr: wrap-bit pointer counter with synchronous clear and increment enable
module fq_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk) begin
        if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + W'(1);
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: flushable instruction FIFO between fetch and the IF/ID register
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int ADDR_W = FQ_ADDR_W,
    parameter int INST_W = FQ_INST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [ADDR_W-1:0]        enq_pc,
    input  logic [INST_W-1:0]        enq_inst,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [ADDR_W-1:0]        deq_pc,
    output logic [INST_W-1:0]        deq_inst,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    logic [PTR_W-1:0] head, tail;
    logic [ADDR_W+INST_W-1:0] mem [DEPTH];
    logic empty, full, enq_fire, deq_fire, clr;
    assign empty = head == tail;
    assign full = head[PTR_W-2:0] == tail[PTR_W-2:0] && head[PTR_W-1] != tail[PTR_W-1];
    assign enq_ready = !full && !rst;
    assign deq_valid = !empty && !rst;
    // a flush cancels any transfer handshaken in the same cycle
    assign clr = rst || flush;
    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && deq_ready && !flush;
    assign {deq_pc, deq_inst} = deq_valid ? mem[head[PTR_W-2:0]] : '0;
    assign count = rst ? '0 : tail - head;
    always_ff @(posedge clk) begin
        if (enq_fire) mem[tail[PTR_W-2:0]] <= {enq_pc, enq_inst};
    end
    fq_ptr #(.W(PTR_W)) u_head (.clk(clk), .clr(clr), .inc(deq_fire), .ptr(head));
    fq_ptr #(.W(PTR_W)) u_tail (.clk(clk), .clr(clr), .inc(enq_fire), .ptr(tail));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table, directed corner sequences and random traffic against a queue model
module tb_fetch_queue;
    import fetch_queue_pkg::*;
    logic clk = 0;
    logic rst = 1, flush = 0, enq_valid = 0, deq_ready = 0;
    logic [31:0] enq_pc = 0, enq_inst = 0;
    logic enq_ready, deq_valid;
    logic [31:0] deq_pc, deq_inst;
    logic [3:0] count;
    int checks = 0, errors = 0;
    fq_entry_t q[$];

    typedef struct {
        logic r, f, ev;
        logic [31:0] pc;
        logic dr, er, dv;
        logic [3:0] cnt;
        logic [31:0] epc;
    } vec_t;
    vec_t tab[13];

    fetch_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_inst(enq_inst),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_inst(deq_inst),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fi(input logic [31:0] p);
        return {p[15:0], ~p[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // one clock: drive, compare before the edge, then advance the model at the edge
    task automatic cyc(input logic r, f, ev, input logic [31:0] p, input logic dr, input int ti = -1);
        logic m_er, m_dv;
        logic [31:0] m_pc, m_inst;
        rst = r; flush = f; enq_valid = ev; enq_pc = p; enq_inst = fi(p); deq_ready = dr;
        @(negedge clk);
        m_er = !r && q.size() < 8;
        m_dv = !r && q.size() > 0;
        m_pc = m_dv ? q[0].pc : 32'h0;
        m_inst = m_dv ? q[0].inst : 32'h0;
        chk("enq_ready", enq_ready, m_er);
        chk("deq_valid", deq_valid, m_dv);
        chk("count", count, r ? 0 : q.size());
        chk("deq_pc", deq_pc, m_pc);
        chk("deq_inst", deq_inst, m_inst);
        if (ti >= 0) begin
            chk("tab_enq_ready", enq_ready, tab[ti].er);
            chk("tab_deq_valid", deq_valid, tab[ti].dv);
            chk("tab_count", count, tab[ti].cnt);
            chk("tab_deq_pc", deq_pc, tab[ti].epc);
            chk("tab_deq_inst", deq_inst, tab[ti].dv ? fi(tab[ti].epc) : 32'h0);
        end
        @(posedge clk);
        if (r || f) q.delete();
        else begin
            if (m_dv && dr) void'(q.pop_front());
            if (m_er && ev) q.push_back('{pc: p, inst: fi(p)});
        end
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        tab[0]  = '{1, 0, 1, 32'h100, 0, 0, 0, 0, 32'h0};
        tab[1]  = '{1, 0, 1, 32'h104, 0, 0, 0, 0, 32'h0};
        tab[2]  = '{0, 0, 0, 32'h0,   0, 1, 0, 0, 32'h0};
        tab[3]  = '{0, 0, 1, 32'h10,  0, 1, 0, 0, 32'h0};
        tab[4]  = '{0, 0, 1, 32'h14,  0, 1, 1, 1, 32'h10};
        tab[5]  = '{0, 0, 0, 32'h0,   1, 1, 1, 2, 32'h10};
        tab[6]  = '{0, 0, 1, 32'h18,  1, 1, 1, 1, 32'h14};
        tab[7]  = '{0, 1, 1, 32'h1C,  1, 1, 1, 1, 32'h18};
        tab[8]  = '{0, 0, 0, 32'h0,   0, 1, 0, 0, 32'h0};
        tab[9]  = '{0, 0, 1, 32'h20,  1, 1, 0, 0, 32'h0};
        tab[10] = '{0, 0, 0, 32'h0,   0, 1, 1, 1, 32'h20};
        tab[11] = '{1, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0};
        tab[12] = '{0, 0, 0, 32'h0,   0, 1, 0, 0, 32'h0};
        @(posedge clk); #1;
        for (int i = 0; i < 13; i++) cyc(tab[i].r, tab[i].f, tab[i].ev, tab[i].pc, tab[i].dr, i);

        // fill to capacity, refuse the ninth, drain in order
        do_reset();
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, i * 4, 0);
        chk("fill_count", count, 8);
        chk("fill_enq_ready", enq_ready, 0);
        cyc(0, 0, 1, 32'h20, 0);
        for (int i = 0; i < 8; i++) begin
            chk("drain_pc", deq_pc, i * 4);
            cyc(0, 0, 0, 0, 1);
        end
        chk("drain_empty", deq_valid, 0);

        // streaming through two pointer wraps
        cyc(0, 0, 1, 32'h100, 0);
        for (int i = 1; i <= 20; i++) begin
            chk("stream_pc", deq_pc, 32'h100 + (i - 1) * 4);
            chk("stream_count", count, 1);
            cyc(0, 0, 1, 32'h100 + i * 4, 1);
        end

        // full queue with simultaneous offer and pop
        do_reset();
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 32'h200 + i * 4, 0);
        cyc(0, 0, 1, 32'h300, 1);
        chk("fulldeq_count", count, 7);
        for (int i = 1; i < 8; i++) begin
            chk("fulldeq_pc", deq_pc, 32'h200 + i * 4);
            cyc(0, 0, 0, 0, 1);
        end
        chk("fulldeq_count_end", count, 0);

        // flush with live handshakes on both sides
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'h500 + i * 4, 0);
        chk("flush_pre_count", count, 5);
        cyc(0, 1, 1, 32'h5F0, 1);
        chk("flush_count", count, 0);
        chk("flush_deq_valid", deq_valid, 0);
        chk("flush_deq_pc", deq_pc, 0);
        cyc(0, 0, 1, 32'h600, 0);
        chk("flush_head_pc", deq_pc, 32'h600);

        // decode stall holds the head steady
        do_reset();
        cyc(0, 0, 1, 32'h40, 0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_pc", deq_pc, 32'h40);
            chk("stall_inst", deq_inst, fi(32'h40));
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 1);
        chk("stall_pop_count", count, 0);

        // random traffic against the queue model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, 1'($urandom),
                $urandom, $urandom_range(0, 3) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
